// File: rtl/oam_line_scanner_pkg.sv
// oam_line_scanner_pkg: OAM entry/result types, scanner FSM states and default sizing.
package oam_line_scanner_pkg;
    localparam int NUM_OAM_SPRITES      = 40;
    localparam int MAX_SPRITES_PER_LINE = 10;
    localparam int OAM_Y_OFFSET         = 16;
    localparam int OAM_AW               = $clog2(NUM_OAM_SPRITES);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;

    typedef struct packed {
        logic       bg_priority;
        logic       y_flip;
        logic       x_flip;
        logic       dmg_palette;
        logic       vram_bank;
        logic [2:0] cgb_palette;
    } SpriteAttributeFlags;

    typedef struct packed {
        logic [7:0]          y;
        logic [7:0]          x;
        logic [7:0]          tile;
        SpriteAttributeFlags flags;
    } OamEntry;

    typedef struct packed {
        logic [OAM_AW-1:0]   index;
        logic [7:0]          x;
        logic [7:0]          tile;
        SpriteAttributeFlags flags;
        logic [3:0]          row;
    } SelectedSprite;
endpackage

// File: rtl/oam_line_scanner_if.sv
// oam_line_scanner_if: scan control, OAM read port and result-buffer read port.
interface oam_line_scanner_if
    import oam_line_scanner_pkg::*;
#(
    parameter int NUM_SPRITES  = NUM_OAM_SPRITES,
    parameter int MAX_PER_LINE = MAX_SPRITES_PER_LINE
);
    localparam int AW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int SW = $clog2(MAX_PER_LINE);

    logic          start;
    logic          abort;
    logic [7:0]    line_y;
    logic          tall_sprites;
    logic          oam_rd_en;
    logic [AW-1:0] oam_addr;
    logic [31:0]   oam_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] sel_count;
    logic [SW-1:0] sel_rd_idx;
    logic [AW+27:0] sel_rd_data;

    modport master (
        output start, abort, line_y, tall_sprites, oam_data, sel_rd_idx,
        input  oam_rd_en, oam_addr, busy, done, sel_count, sel_rd_data
    );
    modport slave (
        input  start, abort, line_y, tall_sprites, oam_data, sel_rd_idx,
        output oam_rd_en, oam_addr, busy, done, sel_count, sel_rd_data
    );
endinterface

// File: rtl/oam_line_scanner_y_match.sv
// oam_y_match: does a sprite with OAM Y cover line_y, and which sprite row lands on it.
module oam_y_match
    import oam_line_scanner_pkg::*;
#(
    parameter int Y_OFFSET = OAM_Y_OFFSET
) (
    input  logic [7:0] line_y_i,
    input  logic [7:0] y_i,
    input  logic       tall_i,
    output logic       hit_o,
    output logic [3:0] row_o
);
    logic [8:0] d;

    assign d     = {1'b0, line_y_i} + 9'(Y_OFFSET) - {1'b0, y_i};
    assign hit_o = !d[8] && d < (tall_i ? 9'd16 : 9'd8);
    assign row_o = d[3:0];
endmodule

// File: rtl/oam_line_scanner.sv
// oam_line_scanner: mode-2 OAM search; walks OAM in index order and buffers up to
// MAX_PER_LINE sprites whose vertical span covers the latched line.
module oam_line_scanner
    import oam_line_scanner_pkg::*;
#(
    parameter int NUM_SPRITES  = NUM_OAM_SPRITES,
    parameter int MAX_PER_LINE = MAX_SPRITES_PER_LINE,
    parameter int Y_OFFSET     = OAM_Y_OFFSET
) (
    input logic clk,
    input logic reset_n,
    oam_line_scanner_if.slave bus
);
    localparam int AW = $clog2(NUM_SPRITES);
    localparam int CW = $clog2(MAX_PER_LINE + 1);

    scan_state_e    state_q;
    logic [7:0]     line_q;
    logic           tall_q, rd_en_q, pend_q, busy_q, done_q;
    logic [AW-1:0]  addr_q, pend_idx_q;
    logic [CW-1:0]  count_q, count_d;
    logic [AW+27:0] slot_q [MAX_PER_LINE];
    OamEntry        entry;
    logic           hit, take, filled, last;
    logic [3:0]     row;

    assign entry = bus.oam_data;

    oam_y_match #(.Y_OFFSET(Y_OFFSET)) u_match (
        .line_y_i(line_q),
        .y_i     (entry.y),
        .tall_i  (tall_q),
        .hit_o   (hit),
        .row_o   (row)
    );

    // pend_q marks the cycle an issued read returns; only SCAN/DRAIN consume it
    always_comb begin
        take    = pend_q && hit && busy_q && !bus.abort && count_q < CW'(MAX_PER_LINE);
        count_d = count_q + CW'(take);
        filled  = take && count_q == CW'(MAX_PER_LINE - 1);
        last    = addr_q == AW'(NUM_SPRITES - 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            line_q     <= '0;
            tall_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            pend_idx_q <= '0;
            count_q    <= '0;
            for (int k = 0; k < MAX_PER_LINE; k++) slot_q[k] <= '0;
        end else begin
            pend_q     <= rd_en_q;
            pend_idx_q <= addr_q;
            done_q     <= 1'b0;
            count_q    <= count_d;
            if (take) slot_q[count_q] <= {pend_idx_q, entry.x, entry.tile, entry.flags, row};
            if (bus.abort && busy_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                count_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        state_q <= IDLE;
                        if (bus.start && !bus.abort) begin
                            state_q <= SCAN;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                            addr_q  <= '0;
                            line_q  <= bus.line_y;
                            tall_q  <= bus.tall_sprites;
                            count_q <= '0;
                        end
                    end
                    SCAN: begin
                        // a fill here means the read issued this cycle is the in-flight
                        // one, so it plays the role of DRAIN and we finish right away
                        if (filled) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            rd_en_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (last) begin
                            state_q <= DRAIN;
                            rd_en_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                    DRAIN: begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.oam_rd_en   = rd_en_q;
    assign bus.oam_addr    = addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sel_count   = count_q;
    assign bus.sel_rd_data = slot_q[bus.sel_rd_idx];
endmodule

// File: tb/tb_oam_line_scanner.sv
// tb_oam_line_scanner: directed scans; expected results are queued at start and
// compared by a monitor whenever the scanner pulses done.
`timescale 1ns/1ps
module tb_oam_line_scanner;
    import oam_line_scanner_pkg::*;

    typedef struct {
        int               done_cyc;
        int               count;
        int               nreads;
        int               last_addr;
        logic [9:0][33:0] slots;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          s0 = 0;
    int          nreads = 0;
    int          last_addr = 0;
    logic [31:0] oam [NUM_OAM_SPRITES];
    exp_t        q [$];

    oam_line_scanner_if bus ();
    oam_line_scanner dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ent(input int i, input logic [7:0] y);
        return {y, 8'(i + 8), 8'(i * 3), 8'(i) ^ 8'hA5};
    endfunction

    function automatic logic [33:0] sel(input int i, input logic [3:0] row);
        SelectedSprite s;
        s.index = OAM_AW'(i);
        s.x     = oam[i][23:16];
        s.tile  = oam[i][15:8];
        s.flags = oam[i][7:0];
        s.row   = row;
        return s;
    endfunction

    task automatic fill(input logic [7:0] y);
        for (int i = 0; i < NUM_OAM_SPRITES; i++) oam[i] = ent(i, y);
    endtask

    task automatic start_scan(input logic [7:0] ly, input logic t);
        @(posedge clk); #1;
        bus.line_y = ly;
        bus.tall_sprites = t;
        bus.start = 1'b1;
        s0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic push(input int offs, input int cnt, input int nr, input int la,
                        input logic [9:0][33:0] sl);
        exp_t e;
        e.done_cyc = s0 + offs;
        e.count = cnt;
        e.nreads = nr;
        e.last_addr = la;
        e.slots = sl;
        q.push_back(e);
    endtask

    task automatic wait_q();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    // OAM RAM model: data follows the read strobe by one cycle
    initial begin
        logic       r;
        logic [5:0] a;
        bus.oam_data = '0;
        forever begin
            @(negedge clk);
            r = bus.oam_rd_en;
            a = bus.oam_addr;
            @(posedge clk); #1;
            bus.oam_data = r ? oam[a] : 32'hDEAD_BEEF;
        end
    end

    // Monitor: pops an expectation per done pulse and walks the result buffer
    initial begin
        exp_t e;
        bus.sel_rd_idx = '0;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("sel_count", bus.sel_count, e.count);
                    check("read_count", nreads, e.nreads);
                    check("last_read_addr", last_addr, e.last_addr);
                    for (int k = 0; k < e.count; k++) begin
                        bus.sel_rd_idx = 4'(k);
                        #1;
                        check($sformatf("slot%0d", k), bus.sel_rd_data, e.slots[k]);
                    end
                end
            end
            if (!bus.busy) nreads = 0;
            if (bus.oam_rd_en) begin
                check("oam_addr_seq", bus.oam_addr, nreads);
                last_addr = bus.oam_addr;
                nreads++;
            end
        end
    end

    initial begin
        logic [9:0][33:0] sl;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.line_y = '0;
        bus.tall_sprites = 1'b0;
        fill(8'd0);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_en", bus.oam_rd_en, 0);
        check("rst_addr", bus.oam_addr, 0);
        check("rst_count", bus.sel_count, 0);
        check("rst_slot0", bus.sel_rd_data, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // nothing on screen: full walk, empty result
        start_scan(8'd50, 1'b0);
        push(42, 0, 40, 39, '0);
        wait_q();

        // single sprite: top row, bottom row, just below, tall bottom row, just below tall
        oam[5] = ent(5, 8'd66);
        sl = '0;
        sl[0] = sel(5, 4'd0);
        start_scan(8'd50, 1'b0); push(42, 1, 40, 39, sl); wait_q();
        sl[0] = sel(5, 4'd7);
        start_scan(8'd57, 1'b0); push(42, 1, 40, 39, sl); wait_q();
        start_scan(8'd58, 1'b0); push(42, 0, 40, 39, '0); wait_q();
        sl[0] = sel(5, 4'd15);
        start_scan(8'd65, 1'b1); push(42, 1, 40, 39, sl); wait_q();
        start_scan(8'd66, 1'b1); push(42, 0, 40, 39, '0); wait_q();

        // mixed edges, including the last entry landing during DRAIN
        fill(8'd0);
        oam[2] = ent(2, 8'd46);
        oam[3] = ent(3, 8'd39);
        oam[7] = ent(7, 8'd38);
        oam[12] = ent(12, 8'd47);
        oam[39] = ent(39, 8'd40);
        sl = '0;
        sl[0] = sel(2, 4'd0);
        sl[1] = sel(3, 4'd7);
        sl[2] = sel(39, 4'd6);
        start_scan(8'd30, 1'b0); push(42, 3, 40, 39, sl); wait_q();

        // every entry hits: early stop after ten, one extra read in flight
        fill(8'd20);
        for (int k = 0; k < 10; k++) sl[k] = sel(k, 4'd0);
        start_scan(8'd4, 1'b0); push(12, 10, 11, 10, sl); wait_q();

        // abort mid-scan, then start+abort together is dropped
        fill(8'd0);
        oam[5] = ent(5, 8'd66);
        start_scan(8'd50, 1'b0);
        step_to(s0 + 20);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_count", bus.sel_count, 0);
        check("abort_rd_en", bus.oam_rd_en, 0);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_busy", bus.busy, 0);
        check("abort_start_rd_en", bus.oam_rd_en, 0);
        check("abort_start_count", bus.sel_count, 0);
        sl = '0;
        sl[0] = sel(5, 4'd7);
        start_scan(8'd57, 1'b0); push(42, 1, 40, 39, sl); wait_q();

        // start held through DONE: back-to-back lines, new line_y latched
        @(posedge clk); #1;
        bus.line_y = 8'd50;
        bus.start = 1'b1;
        s0 = cyc;
        sl[0] = sel(5, 4'd0);
        push(42, 1, 40, 39, sl);
        sl[0] = sel(5, 4'd7);
        push(84, 1, 40, 39, sl);
        @(posedge clk); #1;
        bus.line_y = 8'd57;
        step_to(s0 + 43);
        bus.start = 1'b0;
        step_to(s0 + 60);
        bus.start = 1'b1;
        bus.line_y = 8'd58;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_q();
        repeat (4) @(posedge clk);

        // asynchronous reset mid-scan, then a clean scan
        start_scan(8'd50, 1'b0);
        step_to(s0 + 15);
        check("pre_reset_count", bus.sel_count, 1);
        #5 reset_n = 1'b0;
        #1;
        check("areset_busy", bus.busy, 0);
        check("areset_rd_en", bus.oam_rd_en, 0);
        check("areset_count", bus.sel_count, 0);
        check("areset_addr", bus.oam_addr, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sl[0] = sel(5, 4'd15);
        start_scan(8'd65, 1'b1); push(42, 1, 40, 39, sl); wait_q();

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
